fp16_operand_entry: RTL and testbench

- Upstream stage for the half-precision multiplier and display path: replaces hard-coded operands with user entry on the DE10-Lite.
- Builds two IEEE-754 binary16 operands (num_1, num_2) one hex nibble at a time, from sw_nibble switches and two pushbuttons.
- Presents the finished operands with a one-cycle valid strobe and a level ready flag; exposes the in-progress word for live display.

---
 rtl/fp16_operand_entry.sv | 244 ++++++++++++++++++++++++
 tb/tb_fp16_operand_entry.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_operand_entry.sv
// -----------------------------------------------------------------------------
// fp16_operand_entry
//
// Builds two 16-bit (IEEE-754 binary16) operands one hex nibble at a time from
// four slide switches and two active-low pushbuttons, then hands them to the
// downstream multiplier / display path.
//
// Ports:
//   clock          system clock (50 MHz on the board)
//   reset_n        asynchronous active-low reset, synchronous release
//   key_next_n     pushbutton (active-low, asynchronous): write sw_nibble
//   key_enter_n    pushbutton (active-low, asynchronous): commit operand
//   sw_nibble      hex digit to write into the working word
//   num_1, num_2   committed operands A and B
//   operands_valid one-cycle strobe, aligned with the first cycle num_2 shows
//                  its newly committed value
//   operands_ready level, high while both operands are complete (DONE)
//   entry_word     working word currently being edited (live display)
//   entry_sel      0 = editing A, 1 = editing B
//   nibble_idx     next nibble to write, 0 = bits[15:12] .. 3 = bits[3:0]
//
// Operand bits are opaque: NaN/Inf/denormal patterns pass through untouched.
// -----------------------------------------------------------------------------
module fp16_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_next_n,
    input  logic        key_enter_n,
    input  logic [3:0]  sw_nibble,
    output logic [15:0] num_1,
    output logic [15:0] num_2,
    output logic        operands_valid,
    output logic        operands_ready,
    output logic [15:0] entry_word,
    output logic        entry_sel,
    output logic [1:0]  nibble_idx
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Key index 0 = next, 1 = enter.
    localparam int unsigned K_NEXT  = 0;
    localparam int unsigned K_ENTER = 1;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Replace the nibble selected by idx (0 = most significant) with nib.
    function automatic logic [15:0] put_nibble(input logic [15:0] word,
                                               input logic [1:0]  idx,
                                               input logic [3:0]  nib);
        logic [15:0] w;
        w = word;
        case (idx)
            2'd0:    w[15:12] = nib;
            2'd1:    w[11:8]  = nib;
            2'd2:    w[7:4]   = nib;
            2'd3:    w[3:0]   = nib;
            default: w        = word;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Key conditioning: synchronizer, debounce, press-event pulse
    // ------------------------------------------------------------------
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    // armed_q: the key has been seen released since reset; a key held through
    // reset must be released before its next press can produce an event.
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       fall_q, fall_d;
    logic [1:0]       evt_q;

    // Debounce next-state: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample
    // restarts the count.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k] = deb_q[k];
            cnt_d[k] = cnt_q[k];
            if (sync2_q[k] == deb_q[k]) begin
                cnt_d[k] = CNT_ZERO;
            end else if (cnt_q[k] == CNT_LAST) begin
                deb_d[k] = sync2_q[k];
                cnt_d[k] = CNT_ZERO;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
        armed_d = armed_q | (sync2_q & deb_q);
        fall_d  = armed_q & deb_q & ~deb_d;
    end

    // Key pipeline registers. Synchronizers reset to "pressed" so a key held
    // across reset is never mistaken for a released one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            deb_q   <= 2'b11;
            armed_q <= 2'b00;
            fall_q  <= 2'b00;
            evt_q   <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= CNT_ZERO;
            end
        end else begin
            sync1_q <= {key_enter_n, key_next_n};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            armed_q <= armed_d;
            fall_q  <= fall_d;
            // Event is high the cycle after the debounced level falls.
            evt_q   <= fall_q;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    logic evt_next_s, evt_enter_s;
    assign evt_next_s  = evt_q[K_NEXT];
    assign evt_enter_s = evt_q[K_ENTER];

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only the enter event moves the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A: begin
                if (evt_enter_s) state_d = ST_ENTER_B;
                else             state_d = ST_ENTER_A;
            end
            ST_ENTER_B: begin
                if (evt_enter_s) state_d = ST_DONE;
                else             state_d = ST_ENTER_B;
            end
            ST_DONE: begin
                if (evt_enter_s) state_d = ST_ENTER_A;
                else             state_d = ST_DONE;
            end
            default: state_d = ST_ENTER_A;
        endcase
    end

    logic [15:0] num_1_q, num_1_d;
    logic [15:0] num_2_q, num_2_d;
    logic [15:0] word_q,  word_d;
    logic [1:0]  idx_q,   idx_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        sel_q,   sel_d;

    // Output / datapath logic. Enter wins over a coincident next event.
    always_comb begin
        num_1_d = num_1_q;
        num_2_d = num_2_q;
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        case (state_q)
            ST_ENTER_A, ST_ENTER_B: begin
                if (evt_enter_s) begin
                    if (state_q == ST_ENTER_A) begin
                        num_1_d = word_q;
                    end else begin
                        num_2_d = word_q;
                        valid_d = 1'b1;
                    end
                    word_d = 16'h0000;
                    idx_d  = 2'd0;
                end else if (evt_next_s) begin
                    word_d = put_nibble(word_q, idx_q, sw_nibble);
                    idx_d  = idx_q + 2'd1;   // wraps 3 -> 0
                end else begin
                    word_d = word_q;
                end
            end
            ST_DONE: begin
                word_d = word_q;             // next events ignored
            end
            default: begin
                word_d = 16'h0000;
                idx_d  = 2'd0;
            end
        endcase
        ready_d = (state_d == ST_DONE);
        sel_d   = (state_d == ST_ENTER_B);
    end

    // Registered outputs, aligned with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            num_1_q <= 16'h0000;
            num_2_q <= 16'h0000;
            word_q  <= 16'h0000;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            num_1_q <= num_1_d;
            num_2_q <= num_2_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
        end
    end

    assign num_1          = num_1_q;
    assign num_2          = num_2_q;
    assign entry_word     = word_q;
    assign nibble_idx     = idx_q;
    assign operands_valid = valid_q;
    assign operands_ready = ready_q;
    assign entry_sel      = sel_q;

endmodule

// File: tb/tb_fp16_operand_entry.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fp16_operand_entry (DEBOUNCE_CYCLES = 4).
// A behavioural model tracks each key as a sample delay line plus a window of
// the last D synchronized samples, and the entry process as a phase number
// with plain arithmetic on the working word. Outputs are compared with the
// model on every falling clock edge outside reset; scripted scenarios add
// literal expectations.
// -----------------------------------------------------------------------------
module tb_fp16_operand_entry;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_next_n = 1'b1;
    logic        key_enter_n = 1'b1;
    logic [3:0]  sw_nibble = 4'h0;
    logic [15:0] num_1, num_2, entry_word;
    logic        operands_valid, operands_ready, entry_sel;
    logic [1:0]  nibble_idx;

    int vectors = 0;
    int miscompares = 0;

    fp16_operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .key_next_n     (key_next_n),
        .key_enter_n    (key_enter_n),
        .sw_nibble      (sw_nibble),
        .num_1          (num_1),
        .num_2          (num_2),
        .operands_valid (operands_valid),
        .operands_ready (operands_ready),
        .entry_word     (entry_word),
        .entry_sel      (entry_sel),
        .nibble_idx     (nibble_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_k1 [2];          // key sampled one edge ago
    bit          m_k2 [2];          // key sampled two edges ago (= synchronized)
    bit          m_win [2][D];      // last D synchronized samples, [0] newest
    bit          m_deb [2];
    bit          m_armed [2];
    bit          m_fall1 [2];       // debounced fall one edge ago
    bit          m_fall2 [2];       // debounced fall two edges ago
    int          m_phase;           // 0 = A, 1 = B, 2 = done
    logic [15:0] m_n1, m_n2, m_word;
    int          m_idx;
    bit          m_valid;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_k1[k] = 1'b0; m_k2[k] = 1'b0;
                m_deb[k] = 1'b1; m_armed[k] = 1'b0;
                m_fall1[k] = 1'b0; m_fall2[k] = 1'b0;
                for (int i = 0; i < D; i++) m_win[k][i] = 1'b1;
            end
            m_phase = 0; m_n1 = 16'h0; m_n2 = 16'h0; m_word = 16'h0;
            m_idx = 0; m_valid = 1'b0;
        end else begin
            bit act [2];
            for (int k = 0; k < 2; k++) begin
                bit s, all_diff, old_deb, fell;
                s = m_k2[k];
                for (int i = D - 1; i > 0; i--) m_win[k][i] = m_win[k][i-1];
                m_win[k][0] = s;
                old_deb = m_deb[k];
                all_diff = 1'b1;
                for (int i = 0; i < D; i++) if (m_win[k][i] == old_deb) all_diff = 1'b0;
                fell = all_diff && old_deb && m_armed[k];
                if (all_diff) m_deb[k] = s;
                if (s && old_deb) m_armed[k] = 1'b1;
                act[k] = m_fall2[k];
                m_fall2[k] = m_fall1[k];
                m_fall1[k] = fell;
                m_k2[k] = m_k1[k];
                m_k1[k] = (k == 0) ? key_next_n : key_enter_n;
            end
            m_valid = 1'b0;
            if (m_phase < 2) begin
                if (act[1]) begin
                    if (m_phase == 0) m_n1 = m_word;
                    else begin m_n2 = m_word; m_valid = 1'b1; end
                    m_word = 16'h0; m_idx = 0; m_phase = m_phase + 1;
                end else if (act[0]) begin
                    int sh;
                    sh = (3 - m_idx) * 4;
                    m_word = (m_word & ~(16'hF << sh)) | ({12'h000, sw_nibble} << sh);
                    m_idx = (m_idx + 1) % 4;
                end
            end else if (act[1]) begin
                m_phase = 0;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("num_1", num_1, m_n1);
            chk("num_2", num_2, m_n2);
            chk("entry_word", entry_word, m_word);
            chk("nibble_idx", {14'h0, nibble_idx}, 16'(m_idx));
            chk("operands_valid", {15'h0, operands_valid}, {15'h0, m_valid});
            chk("operands_ready", {15'h0, operands_ready}, {15'h0, m_phase == 2});
            chk("entry_sel", {15'h0, entry_sel}, {15'h0, m_phase == 1});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // which: 0 = next, 1 = enter, 2 = both in the same cycle
    task automatic press(input int which, input logic [3:0] nib);
        sw_nibble = nib;
        if (which != 1) key_next_n = 1'b0;
        if (which != 0) key_enter_n = 1'b0;
        tick(D + 7);
        key_next_n = 1'b1;
        key_enter_n = 1'b1;
        tick(D + 4);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_num_1"}, num_1, 16'h0000);
        chk({tag, "_num_2"}, num_2, 16'h0000);
        chk({tag, "_word"}, entry_word, 16'h0000);
        chk({tag, "_idx"}, {14'h0, nibble_idx}, 16'h0000);
        chk({tag, "_ready"}, {15'h0, operands_ready}, 16'h0000);
        chk({tag, "_valid"}, {15'h0, operands_valid}, 16'h0000);
        chk({tag, "_sel"}, {15'h0, entry_sel}, 16'h0000);
    endtask

    initial begin
        int vcnt;
        int n;
        logic [3:0] seq_a [4];
        logic [3:0] seq_b [4];
        seq_a = '{4'hC, 4'h4, 4'h1, 4'hA};
        seq_b = '{4'h4, 4'h5, 4'h8, 4'h0};

        tick(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick(4);

        // Operand A = C41A, operand B = 4580
        for (int i = 0; i < 4; i++) press(0, seq_a[i]);
        chk("pin_word_a", entry_word, 16'hC41A);
        press(1, 4'h0);
        chk("pin_num_1", num_1, 16'hC41A);
        chk("pin_sel_b", {15'h0, entry_sel}, 16'h0001);
        for (int i = 0; i < 4; i++) press(0, seq_b[i]);
        vcnt = 0;
        key_enter_n = 1'b0;
        repeat (D + 7) begin @(negedge clock); vcnt += int'(operands_valid); end
        key_enter_n = 1'b1;
        repeat (D + 4) begin @(negedge clock); vcnt += int'(operands_valid); end
        chk("pin_valid_pulses", 16'(vcnt), 16'd1);
        chk("pin_num_2", num_2, 16'h4580);
        chk("pin_ready", {15'h0, operands_ready}, 16'h0001);

        // DONE ignores next; enter returns to A with operands retained
        for (int i = 0; i < 3; i++) press(0, 4'h7);
        chk("pin_done_word", entry_word, 16'h0000);
        chk("pin_done_idx", {14'h0, nibble_idx}, 16'h0000);
        press(1, 4'h0);
        chk("pin_back_ready", {15'h0, operands_ready}, 16'h0000);
        chk("pin_back_num_1", num_1, 16'hC41A);
        chk("pin_back_num_2", num_2, 16'h4580);

        // Bouncing key: toggles every 2 cycles, never stable long enough
        sw_nibble = 4'h9;
        for (int i = 0; i < 10; i++) begin key_next_n = ~key_next_n; tick(2); end
        tick(10);
        chk("pin_bounce_word", entry_word, 16'h0000);
        chk("pin_bounce_idx", {14'h0, nibble_idx}, 16'h0000);

        // Steady press: event 7 cycles after the fall, visible one edge later
        key_next_n = 1'b0;
        n = 0;
        while (nibble_idx == 2'd0 && n < 30) begin @(negedge clock); n++; end
        chk("pin_press_latency", 16'(n), 16'(D + 4));
        if (n < 10) tick(10 - n);
        key_next_n = 1'b1;
        tick(D + 4);
        chk("pin_one_event_idx", {14'h0, nibble_idx}, 16'h0001);
        chk("pin_one_event_word", entry_word, 16'h9000);

        // Wrap: five writes in operand B
        press(1, 4'h0);
        for (int i = 1; i <= 5; i++) press(0, 4'(i));
        chk("pin_wrap_word", entry_word, 16'h5234);
        chk("pin_wrap_idx", {14'h0, nibble_idx}, 16'h0001);

        // Simultaneous next + enter in A: enter wins
        press(1, 4'h0);
        press(1, 4'h0);
        press(0, 4'h1);
        press(0, 4'h2);
        press(2, 4'hF);
        chk("pin_both_num_1", num_1, 16'h1200);
        chk("pin_both_word", entry_word, 16'h0000);
        chk("pin_both_sel", {15'h0, entry_sel}, 16'h0001);

        // Reset mid-B with a key held: no event until release and re-press
        press(0, 4'h3);
        chk("pin_pre_rst_word", entry_word, 16'h3000);
        key_next_n = 1'b0;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        chk_all_zero("midrst");
        reset_n = 1'b1;
        tick(20);
        chk("pin_held_idx", {14'h0, nibble_idx}, 16'h0000);
        chk("pin_held_word", entry_word, 16'h0000);
        key_next_n = 1'b1;
        tick(D + 6);
        press(0, 4'h6);
        chk("pin_repress_word", entry_word, 16'h6000);
        chk("pin_repress_idx", {14'h0, nibble_idx}, 16'h0001);

        // Randomized presses with bounce, occasional reset
        for (int op = 0; op < 150; op++) begin
            int which, hold, gap;
            which = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 2) == 0);
            hold = $urandom_range(1, 12);
            gap = $urandom_range(1, 12);
            sw_nibble = 4'($urandom);
            for (int c = 0; c < hold; c++) begin
                logic lvl;
                lvl = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
                key_next_n  = (which != 1) ? lvl : 1'b1;
                key_enter_n = (which != 0) ? lvl : 1'b1;
                tick(1);
            end
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            key_next_n = 1'b1;
            key_enter_n = 1'b1;
            tick(gap);
        end
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
